// File: rtl/rca_seq_pkg.sv
// ============================================================================
// rca_seq_pkg
// ----------------------------------------------------------------------------
// Shared definitions for the sliced ripple-carry sequencer:
//   - seq_state_e : sequencer states (IDLE, RUN, DONE)
//   - DEF_WIDTH / DEF_SLICE : default operand width and slice width
//   - calc_ns     : number of slices needed to cover the operand width
//   - calc_idx_w  : width of the slice index counter (minimum 1 bit)
//   - full_add    : one full-adder cell, returns {cout, sum}
// ============================================================================
package rca_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_e;

  localparam int DEF_WIDTH = 64;
  localparam int DEF_SLICE = 16;

  function automatic int calc_ns(input int width, input int slice);
    return width / slice;
  endfunction

  // One or two slices still need a 1-bit index so the counter never
  // collapses to a zero-width vector.
  function automatic int calc_idx_w(input int ns);
    if (ns <= 2) begin
      return 1;
    end
    return $clog2(ns);
  endfunction

  function automatic logic [1:0] full_add(input logic a, input logic b,
                                          input logic cin);
    logic s;
    logic co;
    s  = a ^ b ^ cin;
    co = (a & b) | (cin & (a ^ b));
    return {co, s};
  endfunction

endpackage

// File: rtl/rca_slice_sequencer_add_slice.sv
// ============================================================================
// add_slice
// ----------------------------------------------------------------------------
// Purely combinational SLICE-bit ripple-carry adder built as a chain of
// full-adder cells.
//
// Ports:
//   a    [SLICE-1:0] in  : addend slice A
//   b    [SLICE-1:0] in  : addend slice B
//   cin              in  : carry into bit 0
//   s    [SLICE-1:0] out : slice sum
//   cout             out : carry out of bit SLICE-1
// ============================================================================
module add_slice
  import rca_seq_pkg::*;
#(
  parameter int SLICE = DEF_SLICE
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             cin,
  output logic [SLICE-1:0] s,
  output logic             cout
);

  // The carry is walked bit by bit through a local variable; each step is
  // one full-adder cell.
  always_comb begin : p_ripple
    logic       c;
    logic [1:0] fa;
    s    = '0;
    cout = 1'b0;
    c    = cin;
    fa   = 2'b00;
    for (int i = 0; i < SLICE; i++) begin
      fa   = full_add(a[i], b[i], c);
      s[i] = fa[0];
      c    = fa[1];
    end
    cout = c;
  end

endmodule

// File: rtl/rca_slice_sequencer.sv
// ============================================================================
// rca_slice_sequencer
// ----------------------------------------------------------------------------
// Multi-cycle WIDTH-bit adder. One A+B+C0 operation is accepted, then the sum
// is formed SLICE bits per cycle through a single reused ripple-carry slice,
// with the carry held in a flop between slices. Valid/ready on both sides.
//
// Optional feature (macro RCA_SEQ_OVF_EN): adds output Ovf, the signed
// overflow of the addition, valid together with out_valid.
//
// Ports:
//   clk        in  : clock, rising edge
//   rst_n      in  : synchronous active-low reset
//   in_valid   in  : operation request
//   in_ready   out : sequencer can accept an operation (IDLE, not in reset)
//   A, B       in  : addends, WIDTH bits, latched at accept
//   C0         in  : carry-in, latched at accept
//   out_valid  out : S / C_Out valid (DONE)
//   out_ready  in  : consumer accepts the result
//   S          out : sum, WIDTH bits
//   C_Out      out : carry out of the MSB
//   busy       out : high in RUN or DONE
//   Ovf        out : signed overflow (only with RCA_SEQ_OVF_EN)
// ============================================================================
module rca_slice_sequencer
  import rca_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SLICE = DEF_SLICE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             C0,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             C_Out,
  output logic             busy
`ifdef RCA_SEQ_OVF_EN
  ,
  output logic             Ovf
`endif
);

  localparam int NS    = calc_ns(WIDTH, SLICE);
  localparam int IDX_W = calc_idx_w(NS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NS - 1);

  if ((SLICE < 1) || ((WIDTH % SLICE) != 0)) begin : g_bad_params
    $error("rca_slice_sequencer: WIDTH must be a positive multiple of SLICE");
  end

  seq_state_e       state;
  seq_state_e       state_nx;
  logic             accept;
  logic             last_slice;

  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] s_reg;
  logic             carry;
  logic             c_out_reg;
  logic [IDX_W-1:0] idx;

  logic [SLICE-1:0] a_slice;
  logic [SLICE-1:0] b_slice;
  logic [SLICE-1:0] slice_s;
  logic             slice_cout;

  assign a_slice = a_reg[int'(idx)*SLICE +: SLICE];
  assign b_slice = b_reg[int'(idx)*SLICE +: SLICE];

  add_slice #(
    .SLICE(SLICE)
  ) u_add_slice (
    .a    (a_slice),
    .b    (b_slice),
    .cin  (carry),
    .s    (slice_s),
    .cout (slice_cout)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // in_ready is gated by rst_n so it reads 0 for the whole reset period,
  // not just after the first reset edge.
  always_comb begin
    state_nx   = state;
    accept     = 1'b0;
    last_slice = 1'b0;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        in_ready = rst_n;
        if (in_valid) begin
          accept   = 1'b1;
          state_nx = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (idx == LAST_IDX) begin
          last_slice = 1'b1;
          state_nx   = DONE;
        end
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          state_nx = IDLE;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // Datapath. The operands are captured once at accept so input changes
  // during RUN/DONE cannot disturb the result. The index returns to 0 on the
  // last slice so it is already clear for the next operation.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_reg     <= '0;
      b_reg     <= '0;
      s_reg     <= '0;
      carry     <= 1'b0;
      c_out_reg <= 1'b0;
      idx       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_reg <= A;
            b_reg <= B;
            carry <= C0;
            idx   <= '0;
            s_reg <= '0;
          end
        end
        RUN: begin
          s_reg[int'(idx)*SLICE +: SLICE] <= slice_s;
          carry <= slice_cout;
          if (last_slice) begin
            c_out_reg <= slice_cout;
            idx       <= '0;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign S     = s_reg;
  assign C_Out = c_out_reg;

`ifdef RCA_SEQ_OVF_EN
  // Carry into the MSB is recovered from the MSB's own sum bit:
  // a ^ b ^ s = cin for a full adder.
  logic ovf_reg;
  logic msb_cin;

  assign msb_cin = a_slice[SLICE-1] ^ b_slice[SLICE-1] ^ slice_s[SLICE-1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_reg <= 1'b0;
    end else if ((state == RUN) && last_slice) begin
      ovf_reg <= msb_cin ^ slice_cout;
    end
  end

  assign Ovf = ovf_reg;
`endif

endmodule

// File: tb/tb_rca_slice_sequencer.sv
// Testbench for rca_slice_sequencer: directed vectors, a mid-operation reset,
// then randomized operations with random stalls and ignored input noise,
// all compared against an arithmetic reference model.
module tb_rca_slice_sequencer;

  localparam int WIDTH = 64;
  localparam int SLICE = 16;
  localparam int NS    = WIDTH / SLICE;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             C0;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] S;
  logic             C_Out;
  logic             busy;
`ifdef RCA_SEQ_OVF_EN
  logic             Ovf;
`endif

  int check_count = 0;
  int fail_count  = 0;

  rca_slice_sequencer #(
    .WIDTH(WIDTH),
    .SLICE(SLICE)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .C0        (C0),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .S         (S),
    .C_Out     (C_Out),
    .busy      (busy)
`ifdef RCA_SEQ_OVF_EN
    ,
    .Ovf       (Ovf)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [127:0] actual,
                             input logic [127:0] expected);
    check_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  function automatic logic [63:0] rand64();
    return {$urandom(), $urandom()};
  endfunction

  // One complete operation: wait for in_ready, accept, watch RUN, check the
  // result at out_valid, hold it for 'stall' cycles, then hand it off.
  // With 'noisy' set, inputs and out_ready toggle randomly while they must be
  // ignored.
  task automatic applyStimulus(input logic [63:0] a, input logic [63:0] b,
                               input logic c0, input int stall,
                               input bit noisy);
    logic [64:0] expected;
    int          waited;
    int          lat;
    expected = {1'b0, a} + {1'b0, b} + {64'd0, c0};

    waited = 0;
    while (!in_ready && waited < 50) begin
      tick();
      waited++;
    end
    checkOutput("accept_ready", 128'(in_ready), 128'(1));

    in_valid  = 1'b1;
    A         = a;
    B         = b;
    C0        = c0;
    out_ready = 1'b0;
    tick();

    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      checkOutput("run_busy", 128'(busy), 128'(1));
      checkOutput("run_in_ready", 128'(in_ready), 128'(0));
      if (noisy) begin
        in_valid  = 1'($urandom_range(0, 1));
        A         = rand64();
        B         = rand64();
        C0        = 1'($urandom_range(0, 1));
        out_ready = 1'($urandom_range(0, 1));
      end
      tick();
      lat++;
    end
    checkOutput("latency", 128'(lat), 128'(NS));
    checkOutput("sum", 128'({C_Out, S}), 128'(expected));
`ifdef RCA_SEQ_OVF_EN
    checkOutput("ovf", 128'(Ovf),
                128'((a[63] == b[63]) && (expected[63] != a[63])));
`endif

    for (int i = 0; i < stall; i++) begin
      out_ready = 1'b0;
      if (noisy) begin
        in_valid = 1'($urandom_range(0, 1));
        A        = rand64();
        B        = rand64();
      end
      tick();
      checkOutput("stall_valid", 128'(out_valid), 128'(1));
      checkOutput("stall_in_ready", 128'(in_ready), 128'(0));
      checkOutput("stall_sum", 128'({C_Out, S}), 128'(expected));
    end

    out_ready = 1'b1;
    tick();
    checkOutput("handoff_valid", 128'(out_valid), 128'(0));
    checkOutput("handoff_in_ready", 128'(in_ready), 128'(1));
    checkOutput("handoff_busy", 128'(busy), 128'(0));
    out_ready = 1'b0;
    in_valid  = 1'b0;
  endtask

  initial begin
    logic [63:0] ra;
    logic [63:0] rb;
    int          mode;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    A         = '0;
    B         = '0;
    C0        = 1'b0;
    out_ready = 1'b0;

    tick();
    tick();
    checkOutput("rst_in_ready", 128'(in_ready), 128'(0));
    checkOutput("rst_out_valid", 128'(out_valid), 128'(0));
    checkOutput("rst_S", 128'(S), 128'(0));
    checkOutput("rst_C_Out", 128'(C_Out), 128'(0));
    checkOutput("rst_busy", 128'(busy), 128'(0));
`ifdef RCA_SEQ_OVF_EN
    checkOutput("rst_ovf", 128'(Ovf), 128'(0));
`endif
    rst_n = 1'b1;
    #1;
    checkOutput("idle_in_ready", 128'(in_ready), 128'(1));

    applyStimulus(64'h0000_0000_FFFF_FFFF, 64'h1, 1'b0, 0, 1'b0);
    applyStimulus(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 0, 1'b0);
    applyStimulus(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1, 10, 1'b1);
    applyStimulus(64'h0000_FFFF_0000_FFFF, 64'h0000_0000_0001_0001, 1'b0, 2, 1'b1);
    applyStimulus(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1, 1'b0);
    applyStimulus(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 0, 1'b0);
    applyStimulus(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1, 0, 1'b1);

    // Reset asserted during the second RUN cycle aborts the operation.
    in_valid  = 1'b1;
    A         = 64'hFFFF_FFFF_FFFF_FFFF;
    B         = 64'h1;
    C0        = 1'b0;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    checkOutput("abort_S", 128'(S), 128'(0));
    checkOutput("abort_C_Out", 128'(C_Out), 128'(0));
    checkOutput("abort_out_valid", 128'(out_valid), 128'(0));
    checkOutput("abort_busy", 128'(busy), 128'(0));
    checkOutput("abort_in_ready_rst", 128'(in_ready), 128'(0));
    rst_n = 1'b1;
    #1;
    checkOutput("abort_in_ready", 128'(in_ready), 128'(1));
    for (int i = 0; i < 8; i++) begin
      tick();
      checkOutput("abort_no_valid", 128'(out_valid), 128'(0));
    end
    out_ready = 1'b0;

    for (int n = 0; n < 1000; n++) begin
      mode = int'($urandom_range(0, 3));
      case (mode)
        0: begin
          ra = rand64();
          rb = rand64();
        end
        1: begin
          ra = 64'hFFFF_FFFF_FFFF_FFFF;
          rb = 64'($urandom_range(0, 3));
        end
        2: begin
          ra = rand64() | 64'hFFFF_0000_FFFF_0000;
          rb = rand64() & 64'h0000_FFFF_0000_FFFF;
        end
        default: begin
          ra = rand64();
          rb = ~ra;
        end
      endcase
      applyStimulus(ra, rb, 1'($urandom_range(0, 1)),
                    int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
    $finish;
  end

endmodule
